// File: rtl/se_drv_pkg.sv
// Shared types and defaults for the SE request driver: FSM encoding, command record, helpers.
package se_drv_pkg;

    localparam int unsigned DEF_DEPTH   = 4;
    localparam int unsigned DEF_DATA_W  = 128;
    localparam int unsigned DEF_INST_W  = 8;
    localparam int unsigned DEF_LAT_W   = 16;
    localparam int unsigned DEF_TIMEOUT = 1024;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ISSUE  = 2'd1;
    localparam state_t ST_WAIT   = 2'd2;
    localparam state_t ST_REPORT = 2'd3;

    typedef struct packed {
        logic [DEF_INST_W-1:0] inst;
        logic [DEF_DATA_W-1:0] op1;
        logic [DEF_DATA_W-1:0] op2;
        logic [DEF_DATA_W-1:0] cond;
    } cmd_t;

    function automatic logic is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/se_request_driver_if.sv
// SE io_in/io_out link: the driver is the master, the SE core is the slave.
interface se_request_driver_if #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned INST_W = 8
) ();

    logic              io_in_valid;
    logic              io_in_ready;
    logic [INST_W-1:0] io_in_inst;
    logic [DATA_W-1:0] io_in_op1;
    logic [DATA_W-1:0] io_in_op2;
    logic [DATA_W-1:0] io_in_cond;
    logic              io_out_valid;
    logic              io_out_ready;
    logic [DATA_W-1:0] io_out_result;

    modport master (
        output io_in_valid, io_in_inst, io_in_op1, io_in_op2, io_in_cond, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_result
    );

    modport slave (
        input  io_in_valid, io_in_inst, io_in_op1, io_in_op2, io_in_cond, io_out_ready,
        output io_in_ready, io_out_valid, io_out_result
    );

endinterface

// File: rtl/se_drv_fifo.sv
// Synchronous command FIFO; o_can_push is a registered not-full flag (0 while in reset).
module se_drv_fifo
    import se_drv_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = cmd_t
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_head,
    output logic o_can_push,
    output logic o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("se_drv_fifo: DEPTH must be a power of two and >= 2");
    end

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [PTR_W:0]   w_count_next;
    logic             r_can_push;

    assign w_count_next = r_count + (PTR_W + 1)'(i_push) - (PTR_W + 1)'(i_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_can_push <= 1'b0;
        end else begin
            // Pointers are PTR_W wide, so wrap mod DEPTH comes for free.
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count    <= w_count_next;
            r_can_push <= (w_count_next != (PTR_W + 1)'(DEPTH));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head     = r_mem[r_rd_ptr];
    assign o_can_push = r_can_push;
    assign o_empty    = (r_count == '0);

endmodule

// File: rtl/se_request_driver.sv
// Request-side driver for one SE core: queues commands, issues them one at a time and reports
// each result with its accept-to-response latency or a timeout abort.
module se_request_driver
    import se_drv_pkg::*;
#(
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned INST_W  = DEF_INST_W,
    parameter int unsigned LAT_W   = DEF_LAT_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic [INST_W-1:0]   i_cmd_inst,
    input  logic [DATA_W-1:0]   i_cmd_op1,
    input  logic [DATA_W-1:0]   i_cmd_op2,
    input  logic [DATA_W-1:0]   i_cmd_cond,
    se_request_driver_if.master se,
    output logic                o_rpt_valid,
    input  logic                i_rpt_ready,
    output logic [DATA_W-1:0]   o_rpt_result,
    output logic [LAT_W-1:0]    o_rpt_latency,
    output logic                o_rpt_timeout,
    output logic                o_err_stray
);

    if (TIMEOUT == 0 || TIMEOUT >= (64'd1 << LAT_W)) begin : g_bad_timeout
        $error("se_request_driver: TIMEOUT must be in 1 .. 2**LAT_W-1");
    end

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [DATA_W-1:0] cond;
    } drv_cmd_t;

    localparam logic [LAT_W-1:0] TIMEOUT_L = LAT_W'(TIMEOUT);
    localparam logic [LAT_W-1:0] LAT_MAX   = '1;

    state_t            r_state;
    state_t            w_state_next;
    logic [LAT_W-1:0]  r_lat_cnt;
    logic [DATA_W-1:0] r_rpt_result;
    logic [LAT_W-1:0]  r_rpt_latency;
    logic              r_rpt_timeout;
    logic              r_err_stray;

    drv_cmd_t w_cmd_in;
    drv_cmd_t w_head;
    logic     w_can_push;
    logic     w_empty;
    logic     w_push;
    logic     w_pop;
    logic     w_issue;

    assign w_cmd_in = {i_cmd_inst, i_cmd_op1, i_cmd_op2, i_cmd_cond};
    assign w_push   = i_cmd_valid & w_can_push;
    assign w_issue  = (r_state == ST_ISSUE);
    assign w_pop    = w_issue & se.io_in_ready;

    se_drv_fifo #(
        .DEPTH (DEPTH),
        .T     (drv_cmd_t)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_push     (w_push),
        .i_data     (w_cmd_in),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_can_push (w_can_push),
        .o_empty    (w_empty)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (!w_empty) w_state_next = ST_ISSUE;
            ST_ISSUE:  if (se.io_in_ready) w_state_next = ST_WAIT;
            ST_WAIT:   if (se.io_out_valid || r_lat_cnt == TIMEOUT_L) w_state_next = ST_REPORT;
            ST_REPORT: if (i_rpt_ready) w_state_next = w_empty ? ST_IDLE : ST_ISSUE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_lat_cnt     <= '0;
            r_rpt_result  <= '0;
            r_rpt_latency <= '0;
            r_rpt_timeout <= 1'b0;
            r_err_stray   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_ISSUE: if (se.io_in_ready) r_lat_cnt <= LAT_W'(1);
                ST_WAIT: begin
                    // A response arriving on the timeout cycle still counts as a response.
                    if (se.io_out_valid) begin
                        r_rpt_result  <= se.io_out_result;
                        r_rpt_latency <= r_lat_cnt;
                        r_rpt_timeout <= 1'b0;
                    end else if (r_lat_cnt == TIMEOUT_L) begin
                        r_rpt_result  <= '0;
                        r_rpt_latency <= TIMEOUT_L;
                        r_rpt_timeout <= 1'b1;
                    end else if (r_lat_cnt != LAT_MAX) begin
                        r_lat_cnt <= r_lat_cnt + LAT_W'(1);
                    end
                end
                default: ;
            endcase
            if (se.io_out_valid && r_state != ST_WAIT) r_err_stray <= 1'b1;
        end
    end

    // Payload is zeroed outside ISSUE so the FIFO's unreset storage never leaks out.
    assign se.io_in_valid  = w_issue;
    assign se.io_in_inst   = w_issue ? w_head.inst : '0;
    assign se.io_in_op1    = w_issue ? w_head.op1  : '0;
    assign se.io_in_op2    = w_issue ? w_head.op2  : '0;
    assign se.io_in_cond   = w_issue ? w_head.cond : '0;
    assign se.io_out_ready = (r_state == ST_WAIT);

    assign o_cmd_ready   = w_can_push;
    assign o_rpt_valid   = (r_state == ST_REPORT);
    assign o_rpt_result  = r_rpt_result;
    assign o_rpt_latency = r_rpt_latency;
    assign o_rpt_timeout = r_rpt_timeout;
    assign o_err_stray   = r_err_stray;

endmodule

// File: tb/tb_se_request_driver.sv
// Directed + randomized bench for se_request_driver; the bench plays the SE core and keeps a
// queue model of the command FIFO and an expected-report model derived from response timing.
module tb_se_request_driver;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned DW      = 128;
    localparam int unsigned IW      = 8;
    localparam int unsigned LW      = 16;
    localparam int unsigned TIMEOUT = 8;

    typedef struct packed {
        logic [IW-1:0] inst;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        logic [DW-1:0] cond;
    } tcmd_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [IW-1:0] cmd_inst = '0;
    logic [DW-1:0] cmd_op1 = '0;
    logic [DW-1:0] cmd_op2 = '0;
    logic [DW-1:0] cmd_cond = '0;
    logic          rpt_valid;
    logic          rpt_ready = 1'b0;
    logic [DW-1:0] rpt_result;
    logic [LW-1:0] rpt_latency;
    logic          rpt_timeout;
    logic          err_stray;

    se_request_driver_if #(.DATA_W(DW), .INST_W(IW)) se_if ();

    se_request_driver #(
        .DEPTH   (DEPTH),
        .DATA_W  (DW),
        .INST_W  (IW),
        .LAT_W   (LW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_inst    (cmd_inst),
        .i_cmd_op1     (cmd_op1),
        .i_cmd_op2     (cmd_op2),
        .i_cmd_cond    (cmd_cond),
        .se            (se_if),
        .o_rpt_valid   (rpt_valid),
        .i_rpt_ready   (rpt_ready),
        .o_rpt_result  (rpt_result),
        .o_rpt_latency (rpt_latency),
        .o_rpt_timeout (rpt_timeout),
        .o_err_stray   (err_stray)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_fail = 0;
    tcmd_t         exp_q[$];
    tcmd_t         pend;
    tcmd_t         cur;
    bit            exp_stray = 1'b0;
    logic [DW-1:0] exp_res;
    logic [LW-1:0] exp_lat;
    logic          exp_to;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: handshakes are judged from the values presented before the edge.
    task automatic tick();
        bit push_t, acc_t, rst_t;
        push_t = cmd_valid && cmd_ready;
        acc_t  = se_if.io_in_valid && se_if.io_in_ready;
        rst_t  = rst;
        @(posedge clk);
        #1;
        if (rst_t) begin
            exp_q.delete();
            exp_stray = 1'b0;
        end else begin
            if (acc_t && exp_q.size() > 0) cur = exp_q.pop_front();
            if (push_t) begin
                exp_q.push_back(pend);
                cmd_valid = 1'b0;
            end
            chk("cmd_ready", DW'(cmd_ready), DW'(exp_q.size() < DEPTH));
        end
        chk("err_stray", DW'(err_stray), DW'(exp_stray));
        chk("excl_strobes", DW'($onehot0({se_if.io_in_valid, se_if.io_out_ready, rpt_valid})),
            DW'(1'b1));
    endtask

    task automatic set_cmd(input tcmd_t c);
        pend      = c;
        cmd_inst  = c.inst;
        cmd_op1   = c.op1;
        cmd_op2   = c.op2;
        cmd_cond  = c.cond;
        cmd_valid = 1'b1;
    endtask

    function automatic tcmd_t rand_cmd();
        tcmd_t c;
        c.inst = IW'($urandom);
        c.op1  = {$urandom, $urandom, $urandom, $urandom};
        c.op2  = {$urandom, $urandom, $urandom, $urandom};
        c.cond = {$urandom, $urandom, $urandom, $urandom};
        return c;
    endfunction

    task automatic enqueue(input tcmd_t c);
        set_cmd(c);
        for (int i = 0; i < 40 && cmd_valid; i++) tick();
        chk("enq_accepted", DW'(cmd_valid), DW'(1'b0));
        cmd_valid = 1'b0;
    endtask

    // Wait for a request, check it is the oldest queued command, stall, then accept it.
    task automatic issue(input int stall);
        for (int i = 0; i < 20 && !se_if.io_in_valid; i++) tick();
        chk("issue_valid", DW'(se_if.io_in_valid), DW'(1'b1));
        chk("model_nonempty", DW'(exp_q.size() > 0), DW'(1'b1));
        for (int s = 0; s <= stall; s++) begin
            if (s > 0) tick();
            if (exp_q.size() > 0) begin
                chk("io_in_inst", DW'(se_if.io_in_inst), DW'(exp_q[0].inst));
                chk("io_in_op1", se_if.io_in_op1, exp_q[0].op1);
                chk("io_in_op2", se_if.io_in_op2, exp_q[0].op2);
                chk("io_in_cond", se_if.io_in_cond, exp_q[0].cond);
            end
        end
        se_if.io_in_ready = 1'b1;
        tick();
        se_if.io_in_ready = 1'b0;
        chk("wait_io_out_ready", DW'(se_if.io_out_ready), DW'(1'b1));
    endtask

    // SE answers d cycles after accept; beyond TIMEOUT it stays silent.
    task automatic respond(input int d);
        if (d <= int'(TIMEOUT)) begin
            for (int i = 1; i < d; i++) tick();
            chk("no_early_rpt", DW'(rpt_valid), DW'(1'b0));
            exp_res = cur.op1 * cur.op2;
            se_if.io_out_result = exp_res;
            se_if.io_out_valid  = 1'b1;
            tick();
            se_if.io_out_valid  = 1'b0;
            se_if.io_out_result = '0;
            exp_lat = LW'(d);
            exp_to  = 1'b0;
        end else begin
            for (int i = 1; i < int'(TIMEOUT); i++) tick();
            chk("no_early_timeout", DW'(rpt_valid), DW'(1'b0));
            tick();
            exp_res = '0;
            exp_lat = LW'(TIMEOUT);
            exp_to  = 1'b1;
        end
        chk("rpt_valid", DW'(rpt_valid), DW'(1'b1));
    endtask

    task automatic check_rpt();
        chk("rpt_result", rpt_result, exp_res);
        chk("rpt_latency", DW'(rpt_latency), DW'(exp_lat));
        chk("rpt_timeout", DW'(rpt_timeout), DW'(exp_to));
    endtask

    task automatic report(input int hold);
        check_rpt();
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("rpt_held", DW'(rpt_valid), DW'(1'b1));
            chk("no_issue_in_report", DW'(se_if.io_in_valid), DW'(1'b0));
            check_rpt();
        end
        rpt_ready = 1'b1;
        tick();
        rpt_ready = 1'b0;
        chk("rpt_dropped", DW'(rpt_valid), DW'(1'b0));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_cmd_ready"}, DW'(cmd_ready), '0);
        chk({tag, "_io_in_valid"}, DW'(se_if.io_in_valid), '0);
        chk({tag, "_io_in_data"}, se_if.io_in_op1 | se_if.io_in_op2 | se_if.io_in_cond
            | DW'(se_if.io_in_inst), '0);
        chk({tag, "_io_out_ready"}, DW'(se_if.io_out_ready), '0);
        chk({tag, "_rpt_valid"}, DW'(rpt_valid), '0);
        chk({tag, "_rpt_result"}, rpt_result, '0);
        chk({tag, "_rpt_latency"}, DW'(rpt_latency), '0);
        chk({tag, "_rpt_timeout"}, DW'(rpt_timeout), '0);
        chk({tag, "_err_stray"}, DW'(err_stray), '0);
    endtask

    initial begin
        tcmd_t c;
        int    n;
        se_if.io_in_ready   = 1'b0;
        se_if.io_out_valid  = 1'b0;
        se_if.io_out_result = '0;

        // Reset state
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        // 1: 3*5 answered two cycles after accept
        c = '{inst: 8'h01, op1: 128'd3, op2: 128'd5, cond: 128'd0};
        enqueue(c);
        issue(0);
        respond(2);
        chk("t1_result", rpt_result, 128'd15);
        chk("t1_latency", DW'(rpt_latency), 128'd2);
        report(0);

        // 2: five commands into a 4-deep FIFO with the SE stalled
        for (int i = 0; i < 4; i++) enqueue(rand_cmd());
        chk("t2_full", DW'(cmd_ready), '0);
        set_cmd(rand_cmd());
        tick();
        tick();
        chk("t2_fifth_held", DW'(cmd_valid), DW'(1'b1));
        for (int i = 0; i < 5; i++) begin
            issue(i % 2);
            respond(1 + i);
            report(0);
        end
        chk("t2_fifth_taken", DW'(cmd_valid), '0);

        // 3: timeout, then the boundary where the response lands on the timeout cycle
        enqueue(rand_cmd());
        enqueue(rand_cmd());
        issue(0);
        respond(TIMEOUT + 3);
        chk("t3_timeout", DW'(rpt_timeout), DW'(1'b1));
        report(1);
        issue(0);
        respond(TIMEOUT);
        report(0);

        // 4: report back-pressure for 10 cycles with work queued
        enqueue(rand_cmd());
        enqueue(rand_cmd());
        issue(0);
        respond(3);
        report(10);
        issue(0);
        respond(1);
        report(0);

        // 5: stray response while idle is sticky
        for (int i = 0; i < 3; i++) tick();
        se_if.io_out_valid = 1'b1;
        exp_stray = 1'b1;
        tick();
        se_if.io_out_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("t5_sticky", DW'(err_stray), DW'(1'b1));

        // Randomized traffic
        for (int it = 0; it < 30; it++) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) enqueue(rand_cmd());
            for (int k = 0; k < n; k++) begin
                issue($urandom_range(0, 3));
                respond($urandom_range(1, TIMEOUT + 3));
                report($urandom_range(0, 3));
            end
        end

        // 6: reset while waiting with two commands queued
        for (int i = 0; i < 3; i++) enqueue(rand_cmd());
        issue(0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_zero("t6");
        chk("t6_model_empty", DW'(exp_q.size()), '0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_issue", DW'(se_if.io_in_valid), '0);
        end
        se_if.io_out_valid  = 1'b1;
        se_if.io_out_result = 128'hdead;
        exp_stray = 1'b1;
        tick();
        se_if.io_out_valid  = 1'b0;
        se_if.io_out_result = '0;
        chk("t6_late_stray", DW'(err_stray), DW'(1'b1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("t6_stray_cleared", DW'(err_stray), '0);
        enqueue(rand_cmd());
        issue(1);
        respond(4);
        report(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
